mem_responder_unit: RTL and testbench

MEM_RESPONDER_UNIT -- requirements
Module: mem_responder_unit

---
 rtl/mem_responder_unit.sv | 103 ++++++++++
 tb/tb_mem_responder_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder_unit.sv
// Word-addressed memory responder for an MDR/MAR datapath.
// Each request gets a fixed number of wait states, then a single access.
module mem_responder_unit #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 9,
    parameter int                    WAIT_STATES = 2,
    parameter logic [DATA_WIDTH-1:0] INIT        = '0
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] MDRout,
    output logic [DATA_WIDTH-1:0] Mdatain,
    output logic                  done,
    output logic                  busy,
    output logic                  error
);

    localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAccess,
        StHold
    } state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    wr_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            Mdatain <= INIT;
            done    <= 1'b0;
            busy    <= 1'b0;
            error   <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (read && write) begin
                        error   <= 1'b1;
                        state_q <= StHold;
                    end else if (read || write) begin
                        addr_q <= address;
                        data_q <= MDRout;
                        wr_q   <= write;
                        busy   <= 1'b1;
                        if (WAIT_STATES > 0) begin
                            state_q <= StWait;
                            cnt_q   <= CNT_W'(WAIT_STATES - 1);
                        end else begin
                            state_q <= StAccess;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        state_q <= StAccess;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                StAccess: begin
                    if (!wr_q) begin
                        Mdatain <= mem[addr_q];
                    end
                    done    <= 1'b1;
                    state_q <= StHold;
                end
                StHold: begin
                    // Stay here until the requester lets go, so a held request is served once.
                    if (!read && !write) begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Array has no reset; an aborted request never reaches StAccess.
    always_ff @(posedge clock) begin
        if (state_q == StAccess && wr_q) begin
            mem[addr_q] <= data_q;
        end
    end

endmodule

// File: tb/tb_mem_responder_unit.sv
// Directed bench for mem_responder_unit: a WAIT_STATES=2 instance and a zero-wait instance.
module tb_mem_responder_unit;

    localparam logic [31:0] INIT_A = 32'h5A5A_0001;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        read_a = 1'b0, write_a = 1'b0;
    logic [8:0]  addr_a = '0;
    logic [31:0] wdata_a = '0;
    logic [31:0] rdata_a;
    logic        done_a, busy_a, error_a;

    logic        read_b = 1'b0, write_b = 1'b0;
    logic [8:0]  addr_b = '0;
    logic [31:0] wdata_b = '0;
    logic [31:0] rdata_b;
    logic        done_b, busy_b, error_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    mem_responder_unit #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (9),
        .WAIT_STATES(2),
        .INIT       (INIT_A)
    ) u_dut (
        .clock  (clock),
        .clear  (clear),
        .read   (read_a),
        .write  (write_a),
        .address(addr_a),
        .MDRout (wdata_a),
        .Mdatain(rdata_a),
        .done   (done_a),
        .busy   (busy_a),
        .error  (error_a)
    );

    mem_responder_unit #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (9),
        .WAIT_STATES(0),
        .INIT       (32'h0)
    ) u_dut_zw (
        .clock  (clock),
        .clear  (clear),
        .read   (read_b),
        .write  (write_b),
        .address(addr_b),
        .MDRout (wdata_b),
        .Mdatain(rdata_b),
        .done   (done_b),
        .busy   (busy_b),
        .error  (error_b)
    );

    // One-edge request on the WAIT_STATES=2 instance; inputs are scrambled after E0.
    task automatic run_req(input logic rd, input logic wr, input logic [8:0] a,
                           input logic [31:0] d, output int n_done, output int done_edge,
                           output int n_err, output logic busy_e0, output logic busy_end);
        n_done = 0; done_edge = -1; n_err = 0;
        read_a = rd; write_a = wr; addr_a = a; wdata_a = d;
        @(posedge clock); #1;
        busy_e0 = busy_a;
        if (error_a) n_err++;
        if (done_a) begin n_done++; done_edge = 0; end
        read_a = 1'b0; write_a = 1'b0; addr_a = ~a; wdata_a = ~d;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clock); #1;
            if (done_a) begin n_done++; done_edge = e; end
            if (error_a) n_err++;
        end
        busy_end = busy_a;
    endtask

    task automatic test_reset();
        @(negedge clock); @(negedge clock);
        vectors++;
        if (rdata_a !== INIT_A) begin
            miscompares++; $display("FAIL reset_mdatain: got %h expected %h", rdata_a, INIT_A);
        end
        vectors++;
        if ({done_a, busy_a, error_a} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 000", {done_a, busy_a, error_a});
        end
        clear = 1'b0;
    endtask

    task automatic test_write();
        int nd, de, ne; logic b0, be;
        run_req(1'b0, 1'b1, 9'h010, 32'hDEAD_BEEF, nd, de, ne, b0, be);
        vectors++;
        if (b0 !== 1'b1) begin miscompares++; $display("FAIL write_busy_e0: got %b expected 1", b0); end
        vectors++;
        if (nd !== 1 || de !== 3) begin
            miscompares++; $display("FAIL write_done: got %0d pulses at edge %0d expected 1 at 3", nd, de);
        end
        vectors++;
        if (ne !== 0) begin miscompares++; $display("FAIL write_error: got %0d expected 0", ne); end
        vectors++;
        if (be !== 1'b0) begin miscompares++; $display("FAIL write_busy_end: got %b expected 0", be); end
        vectors++;
        if (rdata_a !== INIT_A) begin
            miscompares++; $display("FAIL write_mdatain: got %h expected %h", rdata_a, INIT_A);
        end
    endtask

    task automatic test_read();
        int nd, de, ne; logic b0, be;
        run_req(1'b1, 1'b0, 9'h010, 32'h0, nd, de, ne, b0, be);
        vectors++;
        if (nd !== 1 || de !== 3) begin
            miscompares++; $display("FAIL read_done: got %0d pulses at edge %0d expected 1 at 3", nd, de);
        end
        vectors++;
        if (rdata_a !== 32'hDEAD_BEEF) begin
            miscompares++; $display("FAIL read_data: got %h expected deadbeef", rdata_a);
        end
        run_req(1'b0, 1'b1, 9'h011, 32'h1234_5678, nd, de, ne, b0, be);
        vectors++;
        if (nd !== 1 || rdata_a !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL write_keeps_mdatain: got %h (%0d done) expected deadbeef (1 done)", rdata_a, nd);
        end
        run_req(1'b1, 1'b0, 9'h011, 32'h0, nd, de, ne, b0, be);
        vectors++;
        if (rdata_a !== 32'h1234_5678) begin
            miscompares++; $display("FAIL read_011: got %h expected 12345678", rdata_a);
        end
    endtask

    task automatic test_error();
        int nd, de, ne; logic b0, be;
        run_req(1'b1, 1'b1, 9'h010, 32'h1111_1111, nd, de, ne, b0, be);
        vectors++;
        if (ne !== 1) begin miscompares++; $display("FAIL error_pulse: got %0d cycles expected 1", ne); end
        vectors++;
        if (nd !== 0) begin miscompares++; $display("FAIL error_done: got %0d expected 0", nd); end
        run_req(1'b1, 1'b0, 9'h010, 32'h0, nd, de, ne, b0, be);
        vectors++;
        if (rdata_a !== 32'hDEAD_BEEF) begin
            miscompares++; $display("FAIL error_no_write: got %h expected deadbeef", rdata_a);
        end
    endtask

    task automatic test_clear_abort();
        int nd, de, ne; logic b0, be;
        int late_done;
        run_req(1'b0, 1'b1, 9'h020, 32'h0, nd, de, ne, b0, be);
        write_a = 1'b1; addr_a = 9'h020; wdata_a = 32'hCAFE_F00D;
        @(posedge clock); #1;
        write_a = 1'b0;
        @(posedge clock); #1;
        clear = 1'b1;
        #2;
        vectors++;
        if ({done_a, busy_a} !== 2'b00) begin
            miscompares++; $display("FAIL clear_flags: got %b expected 00", {done_a, busy_a});
        end
        vectors++;
        if (rdata_a !== INIT_A) begin
            miscompares++; $display("FAIL clear_mdatain: got %h expected %h", rdata_a, INIT_A);
        end
        @(negedge clock); clear = 1'b0;
        late_done = 0;
        for (int e = 0; e < 6; e++) begin
            @(posedge clock); #1;
            if (done_a) late_done++;
        end
        vectors++;
        if (late_done !== 0) begin miscompares++; $display("FAIL clear_no_done: got %0d expected 0", late_done); end
        run_req(1'b1, 1'b0, 9'h020, 32'h0, nd, de, ne, b0, be);
        vectors++;
        if (rdata_a !== 32'h0) begin
            miscompares++; $display("FAIL clear_no_write: got %h expected 00000000", rdata_a);
        end
    endtask

    task automatic test_hold();
        int nd;
        nd = 0;
        read_a = 1'b1; addr_a = 9'h011;
        for (int e = 0; e < 8; e++) begin
            @(posedge clock); #1;
            if (done_a) nd++;
        end
        vectors++;
        if (busy_a !== 1'b1) begin miscompares++; $display("FAIL hold_busy_held: got %b expected 1", busy_a); end
        read_a = 1'b0;
        @(posedge clock); #1;
        if (done_a) nd++;
        vectors++;
        if (busy_a !== 1'b0) begin miscompares++; $display("FAIL hold_busy_drop: got %b expected 0", busy_a); end
        vectors++;
        if (nd !== 1) begin miscompares++; $display("FAIL hold_one_access: got %0d expected 1", nd); end
        vectors++;
        if (rdata_a !== 32'h1234_5678) begin
            miscompares++; $display("FAIL hold_data: got %h expected 12345678", rdata_a);
        end
    endtask

    task automatic test_zero_wait();
        write_b = 1'b1; addr_b = 9'h005; wdata_b = 32'h0BAD_F00D;
        @(posedge clock); #1;
        write_b = 1'b0; wdata_b = 32'h0;
        @(posedge clock); #1;
        vectors++;
        if (done_b !== 1'b1) begin miscompares++; $display("FAIL zw_write_done: got %b expected 1", done_b); end
        @(posedge clock); #1;
        read_b = 1'b1;
        @(posedge clock); #1;
        read_b = 1'b0; addr_b = 9'h000;
        vectors++;
        if (done_b !== 1'b0) begin miscompares++; $display("FAIL zw_read_e0: got %b expected 0", done_b); end
        @(posedge clock); #1;
        vectors++;
        if (done_b !== 1'b1 || rdata_b !== 32'h0BAD_F00D) begin
            miscompares++;
            $display("FAIL zw_read_e1: got done=%b data=%h expected done=1 data=0badf00d", done_b, rdata_b);
        end
        @(posedge clock); #1;
        vectors++;
        if (done_b !== 1'b0) begin miscompares++; $display("FAIL zw_read_e2: got %b expected 0", done_b); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_error();
        test_clear_abort();
        test_hold();
        test_zero_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
